// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply sequencer that borrows the EX-stage ALU (ADD op) to
// build the low DATA_WIDTH bits of A*B, one multiplier bit per cycle.
module alu_mul_sequencer #(
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         OPCODE_LENGTH = 4,
    parameter logic [OPCODE_LENGTH-1:0]   ALU_ADD_OP    = 4'b0010
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [DATA_WIDTH-1:0]    req_a,
    input  logic [DATA_WIDTH-1:0]    req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_result,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);
    localparam int              CNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [DATA_WIDTH-1:0]  mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    acc_d    = '0;
                    mcand_d  = req_a;
                    mplier_d = req_b;
                    cnt_d    = '0;
                    state_d  = (req_b != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (mplier_q[0])
                    acc_d = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Stop early once no set multiplier bits remain.
                if (mplier_d == '0 || cnt_q == CNT_MAX)
                    state_d = DONE;
            end
            DONE: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready   = (state_q == IDLE) & ~reset;
    assign resp_valid  = (state_q == DONE);
    assign resp_result = acc_q;

    // ALU is only driven with live operands while RUN; otherwise a harmless 0+0.
    assign alu_srca = (state_q == RUN) ? acc_q   : '0;
    assign alu_srcb = (state_q == RUN) ? mcand_q : '0;
    assign alu_op   = ALU_ADD_OP;

endmodule
